// File: rtl/imm_instr_encoder.sv
// Packs register fields and a signed immediate into RV32I load / ALU-immediate / store
// words, range-checks them and streams the results into instruction memory.
module imm_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              range_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t      state, state_nxt;
  logic        hs;
  logic        is_shift;
  logic        imm12_ok;
  logic        legal;
  logic [31:0] word;
  logic [ADDR_W:0] count_inc;

  assign in_ready  = (state == S_ACCEPT) && !full;
  assign hs        = in_valid && in_ready;
  assign mem_we    = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign full      = (count == DEPTH_C);
  assign count_inc = count + (ADDR_W + 1)'(1);

  assign is_shift = (in_fmt == 2'b01) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  // A 12-bit signed immediate fits when bits 31..11 are all copies of the sign.
  assign imm12_ok = (&imm[31:11]) || !(|imm[31:11]);

  // Legality and encoding of the request currently presented.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    legal = 1'b0;
    word  = '0;
    unique case (in_fmt)
      2'b00: begin
        legal = imm12_ok && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      end
      2'b01: begin
        if (is_shift) begin
          legal = !(|imm[31:5]) &&
                  ((funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && (funct3 == 3'b101)));
          word  = {funct7, imm[4:0], rs1, funct3, rd, OP_ALUI};
        end else begin
          legal = imm12_ok;
          word  = {imm[11:0], rs1, funct3, rd, OP_ALUI};
        end
      end
      2'b10: begin
        legal = imm12_ok && (funct3 inside {3'b000, 3'b001, 3'b010});
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  // Next-state logic; stop in ACCEPT wins over a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_ACCEPT;
      S_ACCEPT: begin
        if (stop)              state_nxt = S_IDLE;
        else if (hs && legal)  state_nxt = S_WRITE;
      end
      S_WRITE:  state_nxt = stop ? S_IDLE : S_ACCEPT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= BASE_C;
      mem_wdata <= '0;
      count     <= '0;
      range_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr  <= BASE_C;
            count     <= '0;
            range_err <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (!stop && hs) begin
            if (legal) mem_wdata <= word;
            else       range_err <= 1'b1;
          end
        end
        S_WRITE: begin
          count <= count_inc;
          // Address saturates at the last written word once the session fills.
          if (count_inc != DEPTH_C) mem_addr <= mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed test-plan steps followed by
// randomized requests compared against an arithmetic RV32I encoding model.
module tb_imm_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_fmt = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [2:0]        funct3 = '0;
  logic [6:0]        funct7 = '0;
  logic [31:0]       imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              busy;
  logic              range_err;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;
  logic exp_err = 1'b0;
  logic [31:0] last_wdata;

  imm_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .busy(busy), .range_err(range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Reference: instruction word built from the ISA field layout with integer arithmetic.
  function automatic void ref_encode(input logic [1:0] f, input int d, input int s1, input int s2,
                                     input int f3, input int f7, input logic [31:0] im,
                                     output logic ok, output logic [31:0] w);
    int simm;
    longint unsigned acc;
    bit fits12;
    simm   = int'($signed(im));
    fits12 = (simm >= -2048) && (simm <= 2047);
    ok     = 1'b0;
    acc    = 0;
    case (f)
      2'd0: begin
        ok  = fits12 && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        acc = ((simm & 'hFFF) * (1 << 20)) + s1 * (1 << 15) + f3 * (1 << 12) + d * (1 << 7) + 3;
      end
      2'd1: begin
        if (f3 == 1 || f3 == 5) begin
          ok  = (im < 32) && (f7 == 0 || (f7 == 32 && f3 == 5));
          acc = f7 * (1 << 25) + (im % 32) * (1 << 20) + s1 * (1 << 15) + f3 * (1 << 12)
                + d * (1 << 7) + 19;
        end else begin
          ok  = fits12;
          acc = ((simm & 'hFFF) * (1 << 20)) + s1 * (1 << 15) + f3 * (1 << 12) + d * (1 << 7) + 19;
        end
      end
      2'd2: begin
        ok  = fits12 && (f3 <= 2);
        acc = (((simm & 'hFFF) / 32) * (1 << 25)) + s2 * (1 << 20) + s1 * (1 << 15)
              + f3 * (1 << 12) + (simm & 31) * (1 << 7) + 35;
      end
      default: ok = 1'b0;
    endcase
    w = acc[31:0];
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, range_err, 0);
  endtask

  // mode: 0 = normal, 1 = stop during WRITE, 2 = reset during WRITE
  task automatic send(input string tag, input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im, input int mode);
    logic ok;
    logic [31:0] w;
    int n;
    ref_encode(f, int'(d), int'(s1), int'(s2), int'(f3), int'(f7), im, ok, w);
    in_fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    if (ok) begin
      check({tag, "_we"}, mem_we, 1);
      check({tag, "_addr"}, mem_addr, exp_count);
      check({tag, "_wdata"}, mem_wdata, w);
      last_wdata = mem_wdata;
      if (mode == 1) stop = 1'b1;
      if (mode == 2) reset = 1'b1;
      tick();
      stop  = 1'b0;
      reset = 1'b0;
      if (mode == 2) begin
        exp_count = 0;
        exp_err   = 1'b0;
        check_reset_state({tag, "_rst"});
      end else begin
        exp_count++;
        check({tag, "_we_drop"}, mem_we, 0);
        check({tag, "_count"}, count, exp_count);
        check({tag, "_busy"}, busy, (mode == 0) ? 1 : 0);
        check({tag, "_err"}, range_err, exp_err);
      end
    end else begin
      exp_err = 1'b1;
      check({tag, "_no_we"}, mem_we, 0);
      check({tag, "_err_set"}, range_err, 1);
      check({tag, "_count_hold"}, count, exp_count);
      check({tag, "_busy"}, busy, 1);
    end
  endtask

  function automatic logic [31:0] rand_imm();
    int sel;
    int edges[8] = '{-2049, -2048, 2047, 2048, 0, 31, 32, -1};
    sel = int'($urandom_range(0, 3));
    case (sel)
      0:       return 32'(int'($urandom_range(0, 4095)) - 2048);
      1:       return 32'(edges[$urandom_range(0, 7)]);
      2:       return $urandom;
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Session 1: the four test-plan encodings fill a DEPTH=4 session
    pulse(1'b1, 1'b0);
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    send("load", 2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8, 0);
    check("load_word", last_wdata, 32'h00812283);
    send("addi_neg", 2'b01, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 0);
    check("addi_neg_word", last_wdata, 32'hFFF00093);
    send("srai", 2'b01, 5'd3, 5'd4, 5'd0, 3'b101, 7'b0100000, 32'd4, 0);
    check("srai_word", last_wdata, 32'h40425193);
    send("sw", 2'b10, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, -32'sd4, 0);
    check("sw_word", last_wdata, 32'hFE612E23);
    check("full_set", full, 1);
    check("full_ready", in_ready, 0);

    // Fifth request is held off while full
    in_fmt = 2'b01; rd = 5'd7; rs1 = 5'd1; funct3 = 3'b000; imm = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("held_off_we", mem_we, 0);
    end
    pulse(1'b0, 1'b1);
    in_valid = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_count", count, 4);

    // Session 2: range errors, ignored start
    pulse(1'b1, 1'b0);
    exp_count = 0; exp_err = 1'b0;
    check("restart_count", count, 0);
    send("addi_2048", 2'b01, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd2048, 0);
    send("after_err", 2'b01, 5'd2, 5'd1, 5'd0, 3'b000, 7'd0, 32'd2047, 0);
    send("slli_32", 2'b01, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32, 0);
    pulse(1'b1, 1'b0);
    check("start_ignored_err", range_err, 1);
    check("start_ignored_count", count, exp_count);
    pulse(1'b0, 1'b1);
    check("idle_count_hold", count, exp_count);

    // start and stop together in IDLE: start wins and clears range_err
    pulse(1'b1, 1'b1);
    exp_count = 0; exp_err = 1'b0;
    check("startstop_busy", busy, 1);
    check("startstop_err", range_err, 0);
    check("startstop_count", count, 0);
    send("slli_f7", 2'b01, 5'd1, 5'd1, 5'd0, 3'b001, 7'b0100000, 32'd3, 0);
    send("fmt11", 2'b11, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd0, 0);
    send("lw_bad_f3", 2'b00, 5'd1, 5'd1, 5'd0, 3'b011, 7'd0, 32'd0, 0);
    send("stop_in_write", 2'b00, 5'd9, 5'd3, 5'd0, 3'b100, 7'd0, -32'sd2048, 1);

    // Reset during WRITE
    pulse(1'b1, 1'b0);
    exp_count = 0; exp_err = 1'b0;
    send("reset_in_write", 2'b10, 5'd0, 5'd8, 5'd9, 3'b001, 7'd0, 32'd100, 2);

    // Randomized requests against the reference model
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      logic [1:0] f;
      logic [6:0] f7;
      int sel;
      if (exp_count == DEPTH) begin
        check("rand_full", full, 1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        exp_count = 0; exp_err = 1'b0;
        check("rand_restart_err", range_err, 0);
      end
      f   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 3));
      f7  = (sel == 0) ? 7'($urandom) : ((sel == 1) ? 7'b0100000 : 7'd0);
      send("rand", f, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), f7, rand_imm(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the decode-side immediate extraction: packs register fields plus a 32-bit signed immediate into RV32I load, ALU-immediate and store instruction words.
- Range-checks the immediate and streams encoded words into instruction memory at incrementing addresses.
- Used by the test/boot loader path to build programs for the single-cycle core without an external assembler.
- Covers the same opcode set the core's immediate generator handles: 0000011, 0010011 and 0100011.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- DEPTH, 256, number of words that may be written per load session (DEPTH ≤ 2^ADDR_W).
- BASE_ADDR, 0, word address written by the first encoded instruction after start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a load session; effective only in IDLE.
- stop  in  1  one-cycle pulse that closes the session; returns to IDLE.
- in_valid  in  1  request carries a valid instruction description.
- in_ready  out  1  encoder accepts a request this cycle.
- in_fmt  in  2  00 = load (I), 01 = ALU-immediate (I), 10 = store (S), 11 = reserved.
- rd  in  5  destination register.
- rs1  in  5  base/source register.
- rs2  in  5  store data register (S only).
- funct3  in  3  funct3 field.
- funct7  in  7  upper field for shifts (ALU-I with funct3 001/101 only).
- imm  in  32  signed immediate (for shifts: the shift amount).
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- full  out  1  count == DEPTH.
- busy  out  1  state != IDLE.
- range_err  out  1  sticky error flag; cleared by reset or start.

Behaviour:
- Reset: state = IDLE, in_ready = 0, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0, count = 0, full = 0, busy = 0, range_err = 0.
- States:
  - IDLE: start goes to ACCEPT, sets count = 0 and mem_addr = BASE_ADDR, clears range_err.
  - ACCEPT: in_ready = !full. A handshake (in_valid & in_ready) registers the encoded word and goes to WRITE. If the request is illegal, no write occurs; range_err is set and the state stays in ACCEPT.
  - WRITE: mem_we = 1 for exactly one cycle with mem_addr/mem_wdata stable. The next cycle increments mem_addr and count and returns to ACCEPT.
- Timing: handshake at cycle N gives mem_we at N+1. Peak throughput is one word per 2 cycles.
- Encoding:
  - Load: {imm[11:0], rs1, funct3, rd, 0000011}.
  - ALU-I with funct3 ∉ {001, 101}: {imm[11:0], rs1, funct3, rd, 0010011}.
  - Shift (funct3 001/101): {funct7, imm[4:0], rs1, funct3, rd, 0010011}.
  - Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
- Legality checks; a failure sets range_err:
  - Load, non-shift ALU-I and store: imm[31:11] must be all-equal, i.e. the range −2048..2047.
  - Shift: imm[31:5] must be 0.
  - Shift funct7: must be 0000000, or 0100000 with funct3 = 101 only.
  - Load funct3 must be in {000, 001, 010, 100, 101}.
  - Store funct3 must be in {000, 001, 010}.
  - in_fmt = 11 is illegal.
- full: asserted when count reaches DEPTH. in_ready stays 0 until stop or reset; no address wrap.
- stop: honoured in ACCEPT immediately. In WRITE, the pending write completes first, then the block goes to IDLE. count and mem_addr hold their values in IDLE.
- start while not in IDLE: ignored.
- start and stop in the same IDLE cycle: start wins.
- Reset mid-WRITE: mem_we drops on the following edge; the write is not retried.
- in_valid while in_ready = 0: the request is held off; the requester must keep its fields stable until handshake.

Test Plan:
- Load encoding: start, then fmt = 00, rd = 5, rs1 = 2, funct3 = 010, imm = 8 → mem_we one cycle after handshake, mem_addr = 0, mem_wdata = 0x00812283, count = 1.
- ALU-I with negative immediate: fmt = 01, rd = 1, rs1 = 0, funct3 = 000, imm = 0xFFFFFFFF → 0x FFF00093 at addr 1.
- Shift and store: srai with rd = 3, rs1 = 4, funct7 = 0100000, imm = 4 → 0x40425193; then store with rs2 = 6, rs1 = 2, funct3 = 010, imm = −4 → 0xFE612E23 at consecutive addresses.
- Range errors:
  - addi imm = 2048 → no mem_we, range_err = 1, count unchanged; next legal request is still written.
  - slli imm = 32 → range_err.
  - slli with funct7 = 0100000 → range_err.
  - A new start clears range_err.
- Full: DEPTH = 4, five requests → four writes at addr 0..3, full = 1, in_ready = 0 and the fifth request held off; stop → IDLE, busy = 0, count = 4.
- Reset and boundary events:
  - Reset asserted in WRITE → next cycle all outputs at reset values.
  - start and stop in the same IDLE cycle → ACCEPT.
  - stop in WRITE → the write completes, then IDLE.
